// File: rtl/rns_modarith_fu.sv
// rns_modarith_fu: streaming modular add/sub/negate/pass unit for RNS residues.
// Residues arrive prime-fastest; each beat is reduced modulo the prime selected
// by a per-beat counter. Two register stages, fixed latency 2, no stalls.
module rns_modarith_fu #(
  parameter int NPRIMES = 2,
  parameter int COEFF_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_operation,
  input  logic [1:0]                 op_select,
  input  logic [NPRIMES*COEFF_W-1:0] moduli,
  input  logic                       source0_valid,
  input  logic [COEFF_W-1:0]         source0_coefficient,
  input  logic                       source0_last,
  input  logic                       source1_valid,
  input  logic [COEFF_W-1:0]         source1_coefficient,
  input  logic                       source1_last,
  output logic                       destination_valid,
  output logic [COEFF_W-1:0]         destination_coefficient,
  output logic                       destination_last,
  output logic                       busy,
  output logic                       stream_error
);

  localparam int CNT_W = (NPRIMES > 1) ? $clog2(NPRIMES) : 1;
  localparam logic [CNT_W-1:0] LAST_PRIME = CNT_W'(NPRIMES - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;

  logic [1:0]         op_q;
  logic [CNT_W-1:0]   prime_cnt;
  logic [CNT_W-1:0]   prime_sel;
  logic [COEFF_W-1:0] q_sel;
  logic               misaligned;
  logic               err_q;

  logic [COEFF_W-1:0] a_p1;
  logic [COEFF_W-1:0] b_p1;
  logic [COEFF_W-1:0] q_p1;
  logic [1:0]         op_p1;
  logic               last_p1;
  logic               vld_p1;

  logic [COEFF_W-1:0] res_p2;
  logic               last_p2;
  logic               vld_p2;

  // Modular add with a one-bit-wider intermediate; single conditional subtract.
  function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] a,
                                                 input logic [COEFF_W-1:0] b,
                                                 input logic [COEFF_W-1:0] q);
    logic [COEFF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return COEFF_W'(s);
  endfunction

  // Modular subtract a-b; borrow is repaired by adding q back.
  function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] a,
                                                 input logic [COEFF_W-1:0] b,
                                                 input logic [COEFF_W-1:0] q);
    logic [COEFF_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, q};
    return COEFF_W'(d);
  endfunction

  // Modular negate; zero maps to zero rather than q.
  function automatic logic [COEFF_W-1:0] mod_neg(input logic [COEFF_W-1:0] a,
                                                 input logic [COEFF_W-1:0] q);
    logic [COEFF_W:0] d;
    d = {1'b0, q} - {1'b0, a};
    if (a == '0) d = '0;
    return COEFF_W'(d);
  endfunction

  function automatic logic [COEFF_W-1:0] mod_op(input logic [1:0]         op,
                                                input logic [COEFF_W-1:0] a,
                                                input logic [COEFF_W-1:0] b,
                                                input logic [COEFF_W-1:0] q);
    case (op)
      OP_ADD:  return mod_add(a, b, q);
      OP_SUB:  return mod_sub(a, b, q);
      OP_NEG:  return mod_neg(a, q);
      default: return a;
    endcase
  endfunction

  // A beat coinciding with start_operation is taken at prime 0.
  assign prime_sel = start_operation ? '0 : prime_cnt;

  assign misaligned = (source0_valid != source1_valid) ||
                      (source0_valid && source1_valid && (source0_last != source1_last));

  // Select the modulus for the current beat from the packed prime vector.
  always_comb begin
    q_sel = '0;
    for (int p = 0; p < NPRIMES; p++) begin
      if (prime_sel == CNT_W'(p)) q_sel = moduli[p*COEFF_W +: COEFF_W];
    end
  end

  // Operation latch, per-beat prime counter and sticky misalignment flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_ADD;
      prime_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (start_operation) begin
        op_q      <= op_select;
        prime_cnt <= '0;
      end else if (source0_valid) begin
        prime_cnt <= (source0_last || prime_cnt == LAST_PRIME) ? '0 : prime_cnt + CNT_W'(1);
      end
      if (start_operation) err_q <= 1'b0;
      else if (!op_q[1] && misaligned) err_q <= 1'b1;
    end
  end

  // ---- stage 1: capture operands, modulus, op and framing ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      op_p1   <= OP_ADD;
    end else begin
      vld_p1  <= source0_valid;
      last_p1 <= source0_valid & source0_last;
      op_p1   <= op_q;
    end
  end

  // Stage 1 operand registers; only loaded on a beat.
  always_ff @(posedge clk) begin
    if (source0_valid) begin
      a_p1 <= source0_coefficient;
      b_p1 <= source1_coefficient;
      q_p1 <= q_sel;
    end
  end

  // ---- stage 2: modular result to the destination stream ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      res_p2  <= '0;
    end else begin
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 & last_p1;
      if (vld_p1) res_p2 <= mod_op(op_p1, a_p1, b_p1, q_p1);
    end
  end

  assign destination_valid       = vld_p2;
  assign destination_coefficient = res_p2;
  assign destination_last        = last_p2;
  assign stream_error            = err_q;
  assign busy                    = vld_p1 | vld_p2 | (prime_cnt != '0);

endmodule

// File: tb/tb_rns_modarith_fu.sv
// Testbench for rns_modarith_fu: directed scenarios plus randomized op streams,
// checked every cycle against a cycle-indexed behavioural model.
module tb_rns_modarith_fu;

  localparam int NCOEFF  = 2;
  localparam int NPRIMES = 2;
  localparam int COEFF_W = 8;
  localparam int MASK    = (1 << COEFF_W) - 1;

  logic                       clk;
  logic                       reset_n;
  logic                       start_operation;
  logic [1:0]                 op_select;
  logic [NPRIMES*COEFF_W-1:0] moduli;
  logic                       source0_valid;
  logic [COEFF_W-1:0]         source0_coefficient;
  logic                       source0_last;
  logic                       source1_valid;
  logic [COEFF_W-1:0]         source1_coefficient;
  logic                       source1_last;
  logic                       destination_valid;
  logic [COEFF_W-1:0]         destination_coefficient;
  logic                       destination_last;
  logic                       busy;
  logic                       stream_error;

  rns_modarith_fu #(.NPRIMES(NPRIMES), .COEFF_W(COEFF_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .start_operation         (start_operation),
    .op_select               (op_select),
    .moduli                  (moduli),
    .source0_valid           (source0_valid),
    .source0_coefficient     (source0_coefficient),
    .source0_last            (source0_last),
    .source1_valid           (source1_valid),
    .source1_coefficient     (source1_coefficient),
    .source1_last            (source1_last),
    .destination_valid       (destination_valid),
    .destination_coefficient (destination_coefficient),
    .destination_last        (destination_last),
    .busy                    (busy),
    .stream_error            (stream_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic meaning of each op; out-of-range
  // operands follow the literal conditional formulas truncated to COEFF_W.
  function automatic int ref_result(int op, int a, int b, int q);
    int r;
    if (a < q && b < q) begin
      case (op)
        0:       r = (a + b) % q;
        1:       r = (a - b + q) % q;
        2:       r = (q - a) % q;
        default: r = a;
      endcase
    end else begin
      case (op)
        0:       r = (a + b >= q) ? a + b - q : a + b;
        1:       r = (a >= b) ? a - b : a - b + q;
        2:       r = (a == 0) ? 0 : q - a;
        default: r = a;
      endcase
    end
    return r & MASK;
  endfunction

  // Behavioural model: expectations per absolute output cycle.
  int m_op, m_cnt, m_err, m_hold, cyc, pidx, mq;
  bit ev[4];
  int ec[4];
  bit el[4];
  bit e_v, e_l, e_busy, e_err;
  int e_c;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_op = 0; m_cnt = 0; m_err = 0; m_hold = 0;
      for (int i = 0; i < 4; i++) begin ev[i] = 0; el[i] = 0; ec[i] = 0; end
      e_v = 0; e_c = 0; e_l = 0; e_busy = 0; e_err = 0;
    end else begin
      cyc++;
      pidx = start_operation ? 0 : m_cnt;
      ev[(cyc+1)%4] = 0;
      el[(cyc+1)%4] = 0;
      if (source0_valid) begin
        mq = int'((moduli >> (pidx*COEFF_W))) & MASK;
        ec[(cyc+1)%4] = ref_result(m_op, source0_coefficient, source1_coefficient, mq);
        ev[(cyc+1)%4] = 1;
        el[(cyc+1)%4] = source0_last;
      end
      if (start_operation) m_err = 0;
      else if (m_op < 2 && ((source0_valid != source1_valid) ||
               (source0_valid && source1_valid && source0_last != source1_last))) m_err = 1;
      if (start_operation) begin
        m_op = op_select; m_cnt = 0;
      end else if (source0_valid) begin
        m_cnt = source0_last ? 0 : (m_cnt + 1) % NPRIMES;
      end
      e_v = ev[cyc%4];
      if (e_v) m_hold = ec[cyc%4];
      e_c = m_hold;
      e_l = el[cyc%4];
      e_busy = ev[cyc%4] | ev[(cyc+1)%4] | (m_cnt != 0);
      e_err = (m_err != 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dest_valid", destination_valid, e_v);
      check("dest_coef", destination_coefficient, e_c);
      check("dest_last", destination_last, e_l);
      check("busy", busy, e_busy);
      check("stream_error", stream_error, e_err);
    end
  end

  // Collect emitted results for literal checks of directed scenarios.
  int got[$];
  int expq[$];
  always @(negedge clk) begin
    if (reset_n && destination_valid) got.push_back(int'(destination_coefficient));
  end

  task automatic check_got(input string nm);
    check({nm, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check(nm, (i < got.size()) ? got[i] : -1, expq[i]);
  endtask

  task automatic drive(input bit st, input logic [1:0] op,
                       input bit v0, input int c0, input bit l0,
                       input bit v1, input int c1, input bit l1);
    @(negedge clk);
    start_operation     = st;
    op_select           = op;
    source0_valid       = v0;
    source0_coefficient = COEFF_W'(c0);
    source0_last        = l0;
    source1_valid       = v1;
    source1_coefficient = COEFF_W'(c1);
    source1_last        = l1;
  endtask

  task automatic start_op(input logic [1:0] op);
    drive(1, op, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input int c0, input int c1, input bit l);
    drive(0, 2'b00, 1, c0, l, 1, c1, l);
  endtask

  task automatic beat0(input int c0, input bit l);
    drive(0, 2'b00, 1, c0, l, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nb, op, q, a, b;
    bit v1, l1;
    reset_n = 1'b1;
    start_operation = 0; op_select = 0;
    source0_valid = 0; source0_coefficient = 0; source0_last = 0;
    source1_valid = 0; source1_coefficient = 0; source1_last = 0;
    moduli = {8'd13, 8'd17};
    #1 reset_n = 1'b0;
    #1;
    check("reset_valid", destination_valid, 0);
    check("reset_coef", destination_coefficient, 0);
    check("reset_last", destination_last, 0);
    check("reset_busy", busy, 0);
    check("reset_error", stream_error, 0);
    idle(2);
    reset_n = 1'b1;
    chk_en = 1;
    idle(2);

    // Add: one polynomial of NCOEFF*NPRIMES residues.
    got.delete();
    start_op(2'b00);
    beat(10, 9, 0); beat(5, 7, 0); beat(16, 1, 0); beat(12, 0, 1);
    idle(3);
    check("add_busy_idle", busy, 0);
    expq = {2, 12, 0, 12};
    check_got("add");

    // Sub.
    got.delete();
    start_op(2'b01);
    beat(3, 5, 0); beat(2, 9, 0); beat(16, 16, 0); beat(0, 12, 1);
    idle(3);
    check("sub_error", stream_error, 0);
    expq = {15, 6, 0, 1};
    check_got("sub");

    // Negate with src1 idle.
    got.delete();
    start_op(2'b10);
    beat0(0, 0); beat0(1, 0); beat0(16, 0); beat0(12, 1);
    idle(3);
    check("neg_error", stream_error, 0);
    expq = {0, 12, 1, 1};
    check_got("neg");

    // Bubbles between beats, then a new op started right behind the last beat.
    got.delete();
    start_op(2'b00);
    beat(10, 9, 0); idle(1); beat(5, 7, 0); idle(1);
    beat(16, 1, 0); idle(1); beat(12, 0, 1);
    start_op(2'b00);
    beat(16, 16, 0); beat(12, 12, 0); beat(0, 0, 0); beat(1, 1, 1);
    idle(3);
    expq = {2, 12, 0, 12, 15, 11, 0, 2};
    check_got("bubble");

    // Out-of-range operand follows the literal formula, truncated.
    got.delete();
    start_op(2'b10);
    beat0(5, 0); beat0(20, 1);
    idle(3);
    expq = {12, 249};
    check_got("neg_range");

    // Misalignment: source1 missing on beat 2.
    got.delete();
    start_op(2'b01);
    beat(3, 5, 0);
    drive(0, 2'b00, 1, 2, 0, 0, 9, 0);
    beat(16, 16, 0);
    check("mis_set", stream_error, 1);
    beat(0, 12, 1);
    idle(3);
    check("mis_sticky", stream_error, 1);
    expq = {15, 6, 0, 1};
    check_got("mis");
    start_op(2'b00);
    idle(1);
    check("mis_clear", stream_error, 0);
    idle(1);

    // Reset mid-stream.
    got.delete();
    start_op(2'b00);
    beat(10, 9, 0); beat(5, 7, 0);
    @(posedge clk);
    #2;
    source0_valid = 0; source1_valid = 0; source0_last = 0; source1_last = 0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", destination_valid, 0);
    check("rst_mid_coef", destination_coefficient, 0);
    check("rst_mid_busy", busy, 0);
    idle(2);
    reset_n = 1'b1;
    idle(3);
    check("rst_no_output", got.size(), 0);
    start_op(2'b00);
    beat(10, 9, 0); beat(5, 7, 1);
    idle(3);
    expq = {2, 12};
    check_got("rst_fresh");

    // Randomized ops, lengths, bubbles, moduli and occasional misalignment.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(3);
        moduli = {8'($urandom_range(2, 255)), 8'($urandom_range(2, 255))};
      end
      op = $urandom_range(0, 3);
      start_op(2'(op));
      nb = $urandom_range(1, NCOEFF*NPRIMES + 2);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        q = int'((moduli >> ((k % NPRIMES)*COEFF_W))) & MASK;
        a = $urandom_range(0, q - 1);
        b = $urandom_range(0, q - 1);
        if ($urandom_range(0, 15) == 0) a = $urandom_range(0, MASK);
        v1 = (op < 2) ? 1'b1 : bit'($urandom_range(0, 1));
        l1 = (k == nb - 1);
        if (op < 2 && $urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 1) v1 = ~v1; else l1 = ~l1;
        end
        drive(0, 2'b00, 1, a, (k == nb - 1), v1, b, l1);
      end
      idle($urandom_range(0, 3));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
